// File: rtl/logit_search.sv
// Inverse of the piecewise-constant Q4.12 sigmoid: binary-searches the 28-entry
// level table for the first level >= y_in and returns that segment's x.
module logit_search #(
  parameter bit ROUND_MID = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] y_in,
  output logic [15:0] x_out,
  output logic        done,
  output logic        busy,
  output logic        sat_lo,
  output logic        sat_hi
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEARCH = 2'd0,
    SEL_LO     = 2'd1,
    SEL_HI     = 2'd2,
    SEL_ZERO   = 2'd3
  } sel_t;

  state_t      state_r, state_s;
  sel_t        sel_r, sel_s;
  logic [4:0]  lo_r, lo_s, hi_r, hi_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [15:0] y_r, y_s;
  logic [15:0] x_out_r, x_out_s;
  logic        done_r, done_s;
  logic        busy_r, busy_s;
  logic        sat_lo_r, sat_lo_s;
  logic        sat_hi_r, sat_hi_s;

  logic [5:0]  mid_sum_s;
  logic [4:0]  mid_s;
  logic [4:0]  lo_step_s, hi_step_s;
  logic [15:0] level_s;
  logic [15:0] x_search_s;

  function automatic logic [15:0] level_rom(input logic [4:0] k);
    logic [15:0] lv;
    case (k)
      5'd0:    lv = 16'h0000;
      5'd1:    lv = 16'h0006;
      5'd2:    lv = 16'h000A;
      5'd3:    lv = 16'h0011;
      5'd4:    lv = 16'h001B;
      5'd5:    lv = 16'h002D;
      5'd6:    lv = 16'h004A;
      5'd7:    lv = 16'h0078;
      5'd8:    lv = 16'h00C2;
      5'd9:    lv = 16'h0142;
      5'd10:   lv = 16'h01E8;
      5'd11:   lv = 16'h02EB;
      5'd12:   lv = 16'h044E;
      5'd13:   lv = 16'h060A;
      5'd14:   lv = 16'h09F6;
      5'd15:   lv = 16'h0BB2;
      5'd16:   lv = 16'h0D15;
      5'd17:   lv = 16'h0E18;
      5'd18:   lv = 16'h0EC9;
      5'd19:   lv = 16'h0F3E;
      5'd20:   lv = 16'h0F88;
      5'd21:   lv = 16'h0FB6;
      5'd22:   lv = 16'h0FD3;
      5'd23:   lv = 16'h0FE5;
      5'd24:   lv = 16'h0FEF;
      5'd25:   lv = 16'h0FF6;
      5'd26:   lv = 16'h0FFA;
      default: lv = 16'h1000;
    endcase
    return lv;
  endfunction

  // One lower-bound bisection step on the current [lo, hi] window
  always_comb begin
    mid_sum_s = {1'b0, lo_r} + {1'b0, hi_r};
    mid_s     = mid_sum_s[5:1];
    level_s   = level_rom(mid_s);
    lo_step_s = lo_r;
    hi_step_s = hi_r;
    if (lo_r == hi_r) begin
      lo_step_s = lo_r;
      hi_step_s = hi_r;
    end else if ($signed(level_s) >= $signed(y_r)) begin
      hi_step_s = mid_s;
    end else begin
      lo_step_s = mid_s + 5'd1;
    end
    // After the last step lo == hi, so lo_step_s is the located segment
    x_search_s = 16'h9000 + {lo_step_s, 11'd0} + (ROUND_MID ? 16'h0400 : 16'h0000);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    lo_s     = lo_r;
    hi_s     = hi_r;
    cnt_s    = cnt_r;
    y_s      = y_r;
    x_out_s  = x_out_r;
    done_s   = 1'b0;
    busy_s   = busy_r;
    sat_lo_s = sat_lo_r;
    sat_hi_s = sat_hi_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_SEARCH;
          y_s     = y_in;
          lo_s    = 5'd0;
          hi_s    = 5'd27;
          cnt_s   = 3'd0;
          busy_s  = 1'b1;
          if ($signed(y_in) <= $signed(16'h0000)) begin
            sel_s = SEL_LO;
          end else if ($signed(y_in) >= $signed(16'h1000)) begin
            sel_s = SEL_HI;
          end else if (y_in == 16'h0800) begin
            sel_s = SEL_ZERO;
          end else begin
            sel_s = SEL_SEARCH;
          end
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end
      ST_SEARCH: begin
        lo_s  = lo_step_s;
        hi_s  = hi_step_s;
        cnt_s = cnt_r + 3'd1;
        if (cnt_r == 3'd4) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          case (sel_r)
            SEL_LO: begin
              x_out_s  = 16'h9000;
              sat_lo_s = 1'b1;
              sat_hi_s = 1'b0;
            end
            SEL_HI: begin
              x_out_s  = 16'h7000;
              sat_lo_s = 1'b0;
              sat_hi_s = 1'b1;
            end
            SEL_ZERO: begin
              x_out_s  = 16'h0000;
              sat_lo_s = 1'b0;
              sat_hi_s = 1'b0;
            end
            default: begin
              x_out_s  = x_search_s;
              sat_lo_s = 1'b0;
              sat_hi_s = 1'b0;
            end
          endcase
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      sel_r    <= SEL_SEARCH;
      lo_r     <= 5'd0;
      hi_r     <= 5'd27;
      cnt_r    <= 3'd0;
      y_r      <= 16'h0000;
      x_out_r  <= 16'h0000;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      sat_lo_r <= 1'b0;
      sat_hi_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      lo_r     <= lo_s;
      hi_r     <= hi_s;
      cnt_r    <= cnt_s;
      y_r      <= y_s;
      x_out_r  <= x_out_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
      sat_lo_r <= sat_lo_s;
      sat_hi_r <= sat_hi_s;
    end
  end

  assign x_out  = x_out_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign sat_lo = sat_lo_r;
  assign sat_hi = sat_hi_r;

endmodule

// File: tb/tb_logit_search.sv
// Bench for logit_search: per-cycle comparison against a table-scan model, plus
// directed literal checks on results, saturation, handshake, reset and latency.
module tb_logit_search;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] y_in = 16'h0000;

  logic [15:0] x1, x0;
  logic        d1, d0, b1, b0, sl1, sl0, sh1, sh0;

  int tests = 0;
  int fails = 0;

  logit_search #(.ROUND_MID(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in),
    .x_out(x1), .done(d1), .busy(b1), .sat_lo(sl1), .sat_hi(sh1)
  );

  logit_search #(.ROUND_MID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in),
    .x_out(x0), .done(d0), .busy(b0), .sat_lo(sl0), .sat_hi(sh0)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] LV [0:27] = '{
    16'h0000, 16'h0006, 16'h000A, 16'h0011, 16'h001B, 16'h002D, 16'h004A,
    16'h0078, 16'h00C2, 16'h0142, 16'h01E8, 16'h02EB, 16'h044E, 16'h060A,
    16'h09F6, 16'h0BB2, 16'h0D15, 16'h0E18, 16'h0EC9, 16'h0F3E, 16'h0F88,
    16'h0FB6, 16'h0FD3, 16'h0FE5, 16'h0FEF, 16'h0FF6, 16'h0FFA, 16'h1000};

  // Returns {sat_lo, sat_hi, x}; lower bound found by a plain linear scan
  function automatic logic [17:0] ref_model(input logic [15:0] y, input bit rm);
    int k;
    logic [15:0] x;
    if ($signed(y) <= 0) return {2'b10, 16'h9000};
    if ($signed(y) >= 4096) return {2'b01, 16'h7000};
    if (y == 16'h0800) return {2'b00, 16'h0000};
    k = 0;
    while (k < 27 && $signed(LV[k]) < $signed(y)) k++;
    x = 16'(-28672 + 2048 * k + (rm ? 1024 : 0));
    return {2'b00, x};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: edges remaining until done (-1 = idle, 0 = done cycle)
  int          m_left = -1;
  logic [15:0] m_y = 16'h0000;
  logic [17:0] m_r1 = 18'h0;
  logic [17:0] m_r0 = 18'h0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_left = -1; m_r1 = 18'h0; m_r0 = 18'h0;
      end else if (m_left <= 0) begin
        if (start) begin
          m_y = y_in;
          m_left = 5;
        end else begin
          m_left = -1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_r1 = ref_model(m_y, 1'b1);
          m_r0 = ref_model(m_y, 1'b0);
        end
      end
      @(negedge clk);
      if (rst) begin
        m_left = -1; m_r1 = 18'h0; m_r0 = 18'h0;
      end
      check("busy",    32'(b1),  32'(m_left > 0));
      check("done",    32'(d1),  32'(m_left == 0));
      check("x_out",   32'(x1),  32'(m_r1[15:0]));
      check("sat_lo",  32'(sl1), 32'(m_r1[17]));
      check("sat_hi",  32'(sh1), 32'(m_r1[16]));
      check("busy0",   32'(b0),  32'(m_left > 0));
      check("done0",   32'(d0),  32'(m_left == 0));
      check("x_out0",  32'(x0),  32'(m_r0[15:0]));
      check("sat_lo0", 32'(sl0), 32'(m_r0[17]));
      check("sat_hi0", 32'(sh0), 32'(m_r0[16]));
    end
  end

  // Called at 1 time unit after a rising edge; optionally pokes start mid-search
  task automatic run_op(input logic [15:0] y, input logic [15:0] ex, input logic elo,
                        input logic ehi, input string nm, input bit poke);
    int n;
    bit got;
    start = 1'b1;
    y_in  = y;
    n = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        y_in  = y ^ 16'h0123;
      end
      if (poke && n == 2) begin
        start = 1'b1;
        y_in  = 16'h0100;
      end
      if (poke && n == 3) start = 1'b0;
      if (d1) got = 1'b1;
    end
    check({nm, " latency"}, 32'(n), 32'd6);
    check({nm, " x_out"},   32'(x1), 32'(ex));
    check({nm, " sat_lo"},  32'(sl1), 32'(elo));
    check({nm, " sat_hi"},  32'(sh1), 32'(ehi));
  endtask

  initial begin
    logic [17:0] r;
    int dn;

    check("pin_0c00", 32'(ref_model(16'h0C00, 1'b1)), {14'd0, 2'b00, 16'h1400});
    check("pin_0c00_rm0", 32'(ref_model(16'h0C00, 1'b0)), {14'd0, 2'b00, 16'h1000});
    check("pin_0100", 32'(ref_model(16'h0100, 1'b1)), {14'd0, 2'b00, 16'hDC00});
    check("pin_f000", 32'(ref_model(16'hF000, 1'b1)), {14'd0, 2'b10, 16'h9000});

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({x1, d1, b1, sl1, sh1}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(16'h0C00, 16'h1400, 1'b0, 1'b0, "y0c00", 1'b0);
    check("rm0_y0c00", 32'(x0), 32'h1000);
    repeat (2) @(posedge clk);
    #1;
    run_op(16'h0001, 16'h9C00, 1'b0, 1'b0, "y0001", 1'b0);
    run_op(16'h0100, 16'hDC00, 1'b0, 1'b0, "y0100", 1'b0);
    run_op(16'h0FFF, 16'h6C00, 1'b0, 1'b0, "y0fff", 1'b0);
    run_op(16'h0800, 16'h0000, 1'b0, 1'b0, "y0800", 1'b0);
    run_op(16'hF000, 16'h9000, 1'b1, 1'b0, "yf000", 1'b0);
    run_op(16'h0000, 16'h9000, 1'b1, 1'b0, "y0000", 1'b0);
    run_op(16'h2000, 16'h7000, 1'b0, 1'b1, "y2000", 1'b0);
    run_op(16'h0C00, 16'h1400, 1'b0, 1'b0, "poke", 1'b1);
    run_op(16'h0100, 16'hDC00, 1'b0, 1'b0, "b2b", 1'b0);

    // Asynchronous reset in the third search cycle
    start = 1'b1;
    y_in  = 16'h0C00;
    repeat (3) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({x1, d1, b1, sl1, sh1}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (d1) dn++;
    end
    check("no_done_after_reset", 32'(dn), 32'd0);
    run_op(16'h0C00, 16'h1400, 1'b0, 1'b0, "after_reset", 1'b0);

    for (int i = -16; i <= 16'h1010; i++) begin
      r = ref_model(16'(i), 1'b1);
      run_op(16'(i), r[15:0], r[17], r[16], "sweep", 1'b0);
    end
    for (int i = 0; i < 65536; i += 257) begin
      r = ref_model(16'(i), 1'b1);
      run_op(16'(i), r[15:0], r[17], r[16], "stride", 1'b0);
    end
    r = ref_model(16'h8000, 1'b1);
    run_op(16'h8000, r[15:0], r[17], r[16], "y8000", 1'b0);
    r = ref_model(16'h7FFF, 1'b1);
    run_op(16'h7FFF, r[15:0], r[17], r[16], "y7fff", 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
